// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin resource arbiter family.
package arb_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned IDX_W   = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Callers guarantee at most one bit is set, so OR-ing the set positions yields the index.
  function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = idx | (oh[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping modulo N_REQ.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [IDX_W-1:0] cand_s;
  logic [N_REQ-1:0] rot_s;

  // Scan ptr+1, ptr+2, ... and keep the first requester found.
  always_comb begin
    found  = 1'b0;
    idx    = {IDX_W{1'b0}};
    cand_s = {IDX_W{1'b0}};
    rot_s  = {N_REQ{1'b0}};
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_s = IDX_W'((32'(ptr) + k) % N_REQ);
      rot_s  = req >> cand_s;
      if (!found && rot_s[0]) begin
        found = 1'b1;
        idx   = cand_s;
      end else begin
        found = found;
      end
    end
    onehot = found ? (N_REQ'(1) << idx) : {N_REQ{1'b0}};
  end

endmodule

// File: rtl/shared_resource_arbiter.sv
// Round-robin arbiter serialising N_REQ pipelines onto one shared resource,
// with flush abort and a wait timeout so a hung resource cannot deadlock them.
module shared_resource_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    flush,
  output logic [N_REQ-1:0]        grant,
  output logic                    res_in_valid,
  output logic [DATA_W-1:0]       res_in_data,
  input  logic                    res_out_valid,
  input  logic [DATA_W-1:0]       res_out_data,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              res_in_valid_q, res_in_valid_d;
  logic [DATA_W-1:0] res_in_data_q, res_in_data_d;
  logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic                    pick_found_s;
  logic [IDX_W-1:0]        pick_idx_s;
  logic [N_REQ-1:0]        pick_onehot_s;
  logic [N_REQ*DATA_W-1:0] shifted_s;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .found  (pick_found_s),
    .idx    (pick_idx_s),
    .onehot (pick_onehot_s)
  );

  // Next-state and next-output logic; flush overrides result and timeout.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    res_in_valid_d = 1'b0;
    res_in_data_d  = res_in_data_q;
    resp_valid_d   = {N_REQ{1'b0}};
    resp_data_d    = resp_data_q;
    timeout_err_d  = 1'b0;
    cnt_d          = cnt_q;
    ptr_d          = ptr_q;
    shifted_s      = req_data >> (32'(pick_idx_s) * DATA_W);
    if (flush) begin
      state_d = IDLE;
      grant_d = {N_REQ{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found_s) begin
            grant_d       = pick_onehot_s;
            res_in_data_d = shifted_s[DATA_W-1:0];
            state_d       = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
        ISSUE: begin
          res_in_valid_d = 1'b1;
          cnt_d          = {CNT_W{1'b0}};
          state_d        = WAIT;
        end
        WAIT: begin
          // A result arriving on the timeout boundary still wins.
          if (res_out_valid) begin
            resp_data_d  = res_out_data;
            resp_valid_d = grant_q;
            state_d      = RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_err_d = 1'b1;
            grant_d       = {N_REQ{1'b0}};
            state_d       = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          ptr_d   = oh2idx(MAX_REQ'(grant_q));
          grant_d = {N_REQ{1'b0}};
          state_d = IDLE;
        end
        default: begin
          grant_d = {N_REQ{1'b0}};
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; ptr resets so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      grant_q        <= {N_REQ{1'b0}};
      res_in_valid_q <= 1'b0;
      res_in_data_q  <= {DATA_W{1'b0}};
      resp_valid_q   <= {N_REQ{1'b0}};
      resp_data_q    <= {DATA_W{1'b0}};
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      cnt_q          <= {CNT_W{1'b0}};
      ptr_q          <= IDX_W'(N_REQ - 1);
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      res_in_valid_q <= res_in_valid_d;
      res_in_data_q  <= res_in_data_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
      cnt_q          <= cnt_d;
      ptr_q          <= ptr_d;
    end
  end

  assign grant        = grant_q;
  assign res_in_valid = res_in_valid_q;
  assign res_in_data  = res_in_data_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Randomized self-checking bench for shared_resource_arbiter against a transaction-level model.
module tb_shared_resource_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic [127:0] req_data = 128'd0;
  logic         flush = 1'b0;
  logic [3:0]   grant;
  logic         res_in_valid;
  logic [31:0]  res_in_data;
  logic         res_out_valid = 1'b0;
  logic [31:0]  res_out_data = 32'd0;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_data;
  logic         busy;
  logic         timeout_err;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 3;

  shared_resource_arbiter #(.N_REQ(4), .DATA_W(32), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .flush(flush),
    .grant(grant), .res_in_valid(res_in_valid), .res_in_data(res_in_data),
    .res_out_valid(res_out_valid), .res_out_data(res_out_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [3:0] r, input int lat, input logic [31:0] fixed_res, input bit use_fixed);
    int          ei;
    logic [3:0]  eg;
    logic [31:0] d [4];
    logic [31:0] res;
    ei = model_pick(r, m_ptr);
    eg = 4'b0001 << ei;
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      req_data[i*32 +: 32] = d[i];
    end
    res = use_fixed ? fixed_res : $urandom;
    req = r;
    tick;
    checks++; if (grant !== eg) begin errors++; $display("FAIL grant: got=%b exp=%b", grant, eg); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_on: got=%b exp=1", busy); end
    req = 4'($urandom);
    req_data = {$urandom, $urandom, $urandom, $urandom};
    tick;
    checks++; if (res_in_valid !== 1'b1 || res_in_data !== d[ei])
      begin errors++; $display("FAIL issue: got v=%b d=%h exp v=1 d=%h", res_in_valid, res_in_data, d[ei]); end
    for (int k = 0; k < lat; k++) begin
      tick;
      checks++; if (grant !== eg || res_in_valid !== 1'b0 || resp_valid !== 4'b0000 || timeout_err !== 1'b0)
        begin errors++; $display("FAIL wait: got g=%b iv=%b rv=%b te=%b exp g=%b 0 0000 0", grant, res_in_valid, resp_valid, timeout_err, eg); end
    end
    res_out_valid = 1'b1;
    res_out_data  = res;
    tick;
    res_out_valid = 1'b0;
    res_out_data  = $urandom;
    checks++; if (resp_valid !== eg || resp_data !== res || grant !== eg || timeout_err !== 1'b0)
      begin errors++; $display("FAIL resp: got rv=%b d=%h g=%b te=%b exp rv=%b d=%h g=%b te=0", resp_valid, resp_data, grant, timeout_err, eg, res, eg); end
    tick;
    checks++; if (grant !== 4'b0000 || resp_valid !== 4'b0000 || busy !== 1'b0)
      begin errors++; $display("FAIL done: got g=%b rv=%b busy=%b exp 0000 0000 0", grant, resp_valid, busy); end
    checks++; if (resp_data !== res) begin errors++; $display("FAIL resp_hold: got=%h exp=%h", resp_data, res); end
    m_ptr = ei;
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({grant, res_in_valid, resp_valid, busy, timeout_err} !== 11'd0 || res_in_data !== 32'd0 || resp_data !== 32'd0)
      begin errors++; $display("FAIL reset: got g=%b iv=%b rv=%b b=%b te=%b id=%h rd=%h exp all 0", grant, res_in_valid, resp_valid, busy, timeout_err, res_in_data, resp_data); end
    @(negedge clk);
    reset = 1'b1;
    m_ptr = 3;
    tick;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 32'd0, 1'b0);
  endtask

  task automatic test_basic();
    req_data[31:0] = 32'hA5A5_0001;
    checks++; if (m_ptr != 3) begin end
    run_txn(4'b0001, 1, 32'h0000_1234, 1'b1);
    checks--;
  endtask

  task automatic test_timeout();
    int         n;
    int         ei;
    logic [3:0] eg;
    bit         seen;
    req = 4'b0010;
    ei = model_pick(req, m_ptr);
    eg = 4'b0001 << ei;
    tick;
    checks++; if (grant !== eg) begin errors++; $display("FAIL to_grant: got=%b exp=%b", grant, eg); end
    req = 4'b0000;
    tick;
    checks++; if (res_in_valid !== 1'b1) begin errors++; $display("FAIL to_issue: got=%b exp=1", res_in_valid); end
    n = 0;
    seen = 1'b0;
    while (timeout_err !== 1'b1 && n < 100) begin
      tick;
      n++;
      if (resp_valid !== 4'b0000) seen = 1'b1;
    end
    checks++; if (n != 64) begin errors++; $display("FAIL to_latency: got=%0d exp=64", n); end
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL to_clear: got g=%b b=%b exp 0000 0", grant, busy); end
    checks++; if (seen) begin errors++; $display("FAIL to_noresp: got resp_valid pulse exp none"); end
    tick;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse: got=%b exp=0", timeout_err); end
    run_txn(4'b0010, 2, 32'd0, 1'b0);
  endtask

  task automatic test_flush();
    int         ei;
    logic [3:0] eg;
    req = 4'b1000;
    ei = model_pick(req, m_ptr);
    eg = 4'b0001 << ei;
    tick; req = 4'b0000; tick; tick;
    flush = 1'b1; tick; flush = 1'b0;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || resp_valid !== 4'b0000)
      begin errors++; $display("FAIL flush_wait: got g=%b b=%b rv=%b exp 0000 0 0000", grant, busy, resp_valid); end
    tick;
    res_out_valid = 1'b1; res_out_data = $urandom; tick; res_out_valid = 1'b0;
    checks++; if (resp_valid !== 4'b0000 || busy !== 1'b0 || grant !== 4'b0000)
      begin errors++; $display("FAIL stale: got rv=%b b=%b g=%b exp 0000 0 0000", resp_valid, busy, grant); end
    req = 4'b1000; tick;
    checks++; if (grant !== eg) begin errors++; $display("FAIL flush_ptr: got=%b exp=%b", grant, eg); end
    req = 4'b0000; tick;
    flush = 1'b1; res_out_valid = 1'b1; tick; flush = 1'b0; res_out_valid = 1'b0;
    checks++; if (resp_valid !== 4'b0000 || grant !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0)
      begin errors++; $display("FAIL flush_prio: got rv=%b g=%b b=%b te=%b exp 0000 0000 0 0", resp_valid, grant, busy, timeout_err); end
    tick;
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL flush_prio2: got=%b exp=0000", resp_valid); end
    req = 4'b1000; flush = 1'b1; tick; flush = 1'b0;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got g=%b b=%b exp 0000 0", grant, busy); end
    tick;
    checks++; if (grant !== eg) begin errors++; $display("FAIL after_flush: got=%b exp=%b", grant, eg); end
    req = 4'b0000; tick;
    res_out_valid = 1'b1; res_out_data = 32'hCAFE_0042; tick; res_out_valid = 1'b0;
    checks++; if (resp_valid !== eg || resp_data !== 32'hCAFE_0042)
      begin errors++; $display("FAIL after_flush_resp: got rv=%b d=%h exp rv=%b d=cafe0042", resp_valid, resp_data, eg); end
    tick;
    m_ptr = ei;
  endtask

  task automatic test_reset_mid();
    req = 4'b0100; tick;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rm_grant: got=%b exp=0100", grant); end
    tick; tick;
    reset = 1'b0;
    #1;
    checks++; if ({grant, res_in_valid, resp_valid, busy, timeout_err} !== 11'd0)
      begin errors++; $display("FAIL reset_async: got g=%b iv=%b rv=%b b=%b te=%b exp all 0", grant, res_in_valid, resp_valid, busy, timeout_err); end
    m_ptr = 3;
    req = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    tick;
    run_txn(4'b0101, 1, 32'd0, 1'b0);
  endtask

  task automatic test_boundary();
    run_txn(4'b0011, 62, 32'd0, 1'b0);
    run_txn(4'b0011, 63, 32'd0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) run_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 6)), 32'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
